// File: rtl/uart_receive_controller.sv
// One UART receive frame: start detect, LSB-first assembly, parity/stop/break checks.
// Result registered one pclk after the stop sample; no backpressure, rx_en low aborts to IDLE.
module uart_receive_controller #(
  parameter int DATA_MAX = 8
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                rx_en,
  input  logic                rxd,
  input  logic                sample_edge,
  input  logic                receive_done,
  input  logic [1:0]          wls,
  input  logic                pen,
  input  logic                eps,
  input  logic                sp,
  output logic                sample_restart,
  output logic                receive_frame_counter_clear,
  output logic                receive_frame_counter_en,
  output logic                rx_busy,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_data_valid,
  output logic                parity_error,
  output logic                framing_error,
  output logic                break_detect
);

  localparam int IW = $clog2(DATA_MAX + 2);

  typedef enum logic [1:0] {IDLE, START, FRAME, WAIT_IDLE} state_t;

  state_t                state, state_nxt;
  logic                  rxd_q;
  logic [IW-1:0]         bit_idx;
  logic [IW-1:0]         d_bits;
  logic [DATA_MAX-1:0]   data_r;
  logic                  par_bit;
  logic                  start_fall;
  logic                  frame_begin;
  logic                  shift_smp;
  logic                  stop_smp;
  logic                  data_par;
  logic                  par_exp;

  assign d_bits      = IW'(5) + IW'(wls);
  assign start_fall  = rx_en & rxd_q & ~rxd;
  assign frame_begin = (state == START) & rx_en & sample_edge & ~rxd;
  assign shift_smp   = (state == FRAME) & rx_en & sample_edge & ~receive_done;
  assign stop_smp    = (state == FRAME) & rx_en & sample_edge & receive_done;

  // data_r is cleared at frame start, so unused MSBs never disturb the reduction
  assign data_par = ^data_r;
  assign par_exp  = sp ? ~eps : (eps ? data_par : ~data_par);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      rxd_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rxd_q <= rxd;
    end
  end

  always_comb begin
    state_nxt                   = state;
    receive_frame_counter_clear = 1'b1;
    receive_frame_counter_en    = 1'b0;
    rx_busy                     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_fall) state_nxt = START;
      end
      START: begin
        if (!rx_en)           state_nxt = IDLE;
        else if (sample_edge) state_nxt = rxd ? IDLE : FRAME;
      end
      FRAME: begin
        receive_frame_counter_clear = 1'b0;
        receive_frame_counter_en    = sample_edge;
        if (!rx_en)                            state_nxt = IDLE;
        else if (sample_edge && receive_done)  state_nxt = rxd ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!rx_en || rxd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      bit_idx <= '0;
      data_r  <= '0;
      par_bit <= 1'b0;
    end else if (frame_begin) begin
      bit_idx <= '0;
      data_r  <= '0;
      par_bit <= 1'b0;
    end else if (shift_smp) begin
      for (int i = 0; i < DATA_MAX; i++) begin
        if (bit_idx < d_bits && bit_idx == IW'(i)) data_r[i] <= rxd;
      end
      if (pen && bit_idx == d_bits) par_bit <= rxd;
      bit_idx <= bit_idx + IW'(1);
    end
  end

  // Result outputs hold between frames; aborted frames leave them untouched
  always_ff @(posedge pclk) begin
    if (preset) begin
      sample_restart <= 1'b0;
      rx_data_valid  <= 1'b0;
      rx_data        <= '0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      break_detect   <= 1'b0;
    end else begin
      sample_restart <= (state == IDLE) & start_fall;
      rx_data_valid  <= stop_smp;
      if (stop_smp) begin
        rx_data       <= data_r;
        parity_error  <= pen & (par_bit != par_exp);
        framing_error <= ~rxd;
        break_detect  <= ~rxd & (data_r == '0) & (~pen | ~par_bit);
      end
    end
  end

endmodule

// File: tb/tb_uart_receive_controller.sv
// Directed bench for uart_receive_controller with a frame-counter model and result scoreboard.
module tb_uart_receive_controller;

  logic       pclk = 1'b0;
  logic       preset, rx_en, rxd, sample_edge, receive_done;
  logic [1:0] wls;
  logic       pen, eps, sp;
  logic       sample_restart, receive_frame_counter_clear, receive_frame_counter_en, rx_busy;
  logic [7:0] rx_data;
  logic       rx_data_valid, parity_error, framing_error, break_detect;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;
  int   restart_cnt = 0;
  int   en_cnt = 0;
  int   v0;

  logic [3:0] cnt;
  logic [3:0] n_bits;

  always #5 pclk = ~pclk;

  uart_receive_controller #(.DATA_MAX(8)) dut (
    .pclk                        (pclk),
    .preset                      (preset),
    .rx_en                       (rx_en),
    .rxd                         (rxd),
    .sample_edge                 (sample_edge),
    .receive_done                (receive_done),
    .wls                         (wls),
    .pen                         (pen),
    .eps                         (eps),
    .sp                          (sp),
    .sample_restart              (sample_restart),
    .receive_frame_counter_clear (receive_frame_counter_clear),
    .receive_frame_counter_en    (receive_frame_counter_en),
    .rx_busy                     (rx_busy),
    .rx_data                     (rx_data),
    .rx_data_valid               (rx_data_valid),
    .parity_error                (parity_error),
    .framing_error               (framing_error),
    .break_detect                (break_detect)
  );

  // External frame bit counter: receive_done once data+parity bits are counted
  assign n_bits       = 4'd5 + {2'b00, wls} + {3'b000, pen};
  assign receive_done = sample_edge && (cnt == n_bits);

  always @(posedge pclk) begin
    if (preset || receive_frame_counter_clear) cnt <= '0;
    else if (receive_frame_counter_en)         cnt <= cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (sample_restart) restart_cnt++;
    if (receive_frame_counter_en) en_cnt++;
    if (rx_data_valid) begin
      valid_cnt++;
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      check("rx_data", 32'(rx_data), 32'(e.d));
      check("parity_error", 32'(parity_error), 32'(e.pe));
      check("framing_error", 32'(framing_error), 32'(e.fe));
      check("break_detect", 32'(break_detect), 32'(e.bd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(4);
    sample_edge = 1'b1;
    tick(1);
    sample_edge = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nd, input logic has_par,
                            input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) send_bit(data[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  initial begin
    preset = 1'b1; rx_en = 1'b1; rxd = 1'b1; sample_edge = 1'b0;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    tick(3);
    check("reset_busy", 32'(rx_busy), 32'd0);
    check("reset_clear", 32'(receive_frame_counter_clear), 32'd1);
    check("reset_en", 32'(receive_frame_counter_en), 32'd0);
    check("reset_restart", 32'(sample_restart), 32'd0);
    check("reset_valid", 32'(rx_data_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_flags", {29'd0, parity_error, framing_error, break_detect}, 32'd0);
    preset = 1'b0;
    tick(2);

    // 8N1 0xA5
    v0 = valid_cnt;
    sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("8n1_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("8n1_idle", 32'(rx_busy), 32'd0);

    // 7E1 0x41, parity bit 1 is wrong for even parity
    wls = 2'b10; pen = 1'b1; eps = 1'b1;
    v0 = valid_cnt;
    sb.push_back('{d: 8'h41, pe: 1'b1, fe: 1'b0, bd: 1'b0});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_valid_count", 32'(valid_cnt - v0), 32'd1);

    // 5-bit stick parity (eps=0 -> parity bit must be 1)
    wls = 2'b00; pen = 1'b1; sp = 1'b1; eps = 1'b0;
    v0 = valid_cnt; en_cnt = 0;
    sb.push_back('{d: 8'h15, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1);
    check("stick_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("stick_counter_en_pulses", 32'(en_cnt), 32'd7);

    // Start glitch: low 2 pclks, high at first sample_edge
    wls = 2'b11; pen = 1'b0; sp = 1'b0;
    v0 = valid_cnt; restart_cnt = 0;
    rxd = 1'b0;
    tick(2);
    check("glitch_busy_start", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    tick(2);
    sample_edge = 1'b1;
    tick(1);
    sample_edge = 1'b0;
    tick(1);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    tick(20);
    check("glitch_restart_pulses", 32'(restart_cnt), 32'd1);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Break: rxd low for two 8N1 frame times
    v0 = valid_cnt;
    sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bd: 1'b1});
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    check("break_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("break_wait_busy", 32'(rx_busy), 32'd1);
    check("break_wait_clear", 32'(receive_frame_counter_clear), 32'd1);
    rxd = 1'b1;
    tick(2);
    check("break_release_idle", 32'(rx_busy), 32'd0);
    tick(40);
    check("break_no_second", 32'(valid_cnt - v0), 32'd1);

    // Abort via rx_en after 3rd data bit, then preset mid-frame on retry
    v0 = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_en = 1'b0;
    tick(1);
    check("abort_busy", 32'(rx_busy), 32'd0);
    check("abort_clear", 32'(receive_frame_counter_clear), 32'd1);
    check("abort_flags_held", {30'd0, framing_error, break_detect}, 32'd3);
    rxd = 1'b1;
    tick(2);
    rx_en = 1'b1;
    tick(2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    preset = 1'b1;
    tick(1);
    check("preset_busy", 32'(rx_busy), 32'd0);
    check("preset_clear", 32'(receive_frame_counter_clear), 32'd1);
    check("preset_flags", {29'd0, parity_error, framing_error, break_detect}, 32'd0);
    preset = 1'b0;
    rxd = 1'b1;
    tick(80);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
